// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca4.sv
// 4-bit ripple-carry adder; the single arithmetic element time-shared by the sequencer.
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c_s;

  // Carry ripples from bit 0 upward
  always_comb begin
    c_s    = 5'b0;
    s      = 4'b0;
    c_s[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c_s[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract performed one nibble per clock through a shared rca4,
// with start/busy/done handshake and registered result, carry and overflow.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t               state_r;
  state_t               state_n_s;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     s_r;
  logic                 sub_r;
  logic                 c_r;
  logic                 co_r;
  logic                 ovf_r;
  logic                 busy_r;
  logic                 done_r;
  logic [IDX_W-1:0]     idx_r;
  logic [NIBBLE_W-1:0]  a_nib_s;
  logic [NIBBLE_W-1:0]  b_nib_s;
  logic [NIBBLE_W-1:0]  sum_s;
  logic                 co_s;
  logic                 last_s;

  // Subtraction is a + ~b + 1: invert B here, the +1 enters as the initial carry
  assign a_nib_s = a_r[NIBBLE_W-1:0];
  assign b_nib_s = b_r[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_r}};
  assign last_s  = (idx_r == IDX_LAST);

  rca4 u_rca4 (
    .a  (a_nib_s),
    .b  (b_nib_s),
    .ci (c_r),
    .s  (sum_s),
    .co (co_s)
  );

  // Next-state decode
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_n_s = RUN;
        else       state_n_s = IDLE;
      end
      RUN: begin
        if (last_s) state_n_s = DONE;
        else        state_n_s = RUN;
      end
      DONE:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      busy_r  <= (state_n_s != IDLE);
      done_r  <= (state_n_s == DONE);
    end
  end

  // Operand capture, nibble shifting and result/flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      s_r   <= {WIDTH{1'b0}};
      sub_r <= 1'b0;
      c_r   <= 1'b0;
      co_r  <= 1'b0;
      ovf_r <= 1'b0;
      idx_r <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            c_r   <= sub;
            idx_r <= {IDX_W{1'b0}};
            co_r  <= 1'b0;
            ovf_r <= 1'b0;
          end else begin
            a_r <= a_r;
          end
        end
        RUN: begin
          // Sum enters at the top so the LSB nibble ends up at the bottom after NIB steps
          s_r   <= {sum_s, s_r[WIDTH-1:NIBBLE_W]};
          a_r   <= a_r >> NIBBLE_W;
          b_r   <= b_r >> NIBBLE_W;
          c_r   <= co_s;
          idx_r <= idx_r + IDX_W'(1);
          if (last_s) begin
            co_r  <= co_s;
            ovf_r <= ~(a_nib_s[NIBBLE_W-1] ^ b_nib_s[NIBBLE_W-1])
                     & (sum_s[NIBBLE_W-1] ^ a_nib_s[NIBBLE_W-1]);
          end else begin
            co_r <= co_r;
          end
        end
        default: begin
          a_r <= a_r;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign co   = co_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: cycle-level behavioural model plus hand-computed literal results.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .s       (s),
    .co      (co),
    .ovf     (ovf)
  );

  typedef struct packed {
    logic             chk;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
  } lit_t;

  lit_t lit_q[$];
  int   rd    = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: cycles left until idle, the held result, and the result in flight
  int               m_cnt;
  logic [WIDTH-1:0] m_s;
  logic             m_co;
  logic             m_ovf;
  logic [WIDTH-1:0] p_s;
  logic             p_co;
  logic             p_ovf;

  // Returns {ovf, co, s}
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic sb);
    logic [WIDTH-1:0] yp;
    logic [WIDTH:0]   sum;
    logic             v;
    yp  = sb ? ~y : y;
    sum = {1'b0, x} + {1'b0, yp} + {{WIDTH{1'b0}}, sb};
    v   = (x[WIDTH-1] == yp[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    return {v, sum};
  endfunction

  // Behavioural model: an accepted op keeps busy for NIB+1 cycles, done on the last
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0;
      m_s   <= '0;
      m_co  <= 1'b0;
      m_ovf <= 1'b0;
      p_s   <= '0;
      p_co  <= 1'b0;
      p_ovf <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        {p_ovf, p_co, p_s} <= ref_op(a, b, sub);
        m_cnt <= NIB + 1;
        m_co  <= 1'b0;
        m_ovf <= 1'b0;
      end
    end else begin
      if (m_cnt == 2) begin
        m_s   <= p_s;
        m_co  <= p_co;
        m_ovf <= p_ovf;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chkw(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge and immediately after a reset assertion
  always begin
    @(negedge clk or negedge reset_n);
    #1;
    chk1("busy", busy, m_cnt != 0);
    chk1("done", done, m_cnt == 1);
    if (m_cnt <= 1) begin
      chkw("s", s, m_s);
      chk1("co", co, m_co);
      chk1("ovf", ovf, m_ovf);
    end
    if (!reset_n) begin
      rd = lit_q.size();
    end else if (m_cnt == 1) begin
      if (rd < lit_q.size()) begin
        if (lit_q[rd].chk) begin
          chkw("lit_s", s, lit_q[rd].s);
          chk1("lit_co", co, lit_q[rd].co);
          chk1("lit_ovf", ovf, lit_q[rd].ovf);
          chkw("model_s", m_s, lit_q[rd].s);
          chk1("model_co", m_co, lit_q[rd].co);
          chk1("model_ovf", m_ovf, lit_q[rd].ovf);
        end
        rd++;
      end else begin
        chk1("lit_queue", 1'b0, 1'b1);
      end
    end
  end

  // One op: start for one cycle, scramble operands while busy, return in the next idle cycle
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sb,
                        input logic c, input logic [WIDTH-1:0] es, input logic eco, input logic eov);
    lit_q.push_back(lit_t'{chk: c, s: es, co: eco, ovf: eov});
    a     = x;
    b     = y;
    sub   = sb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    sub   = 1'($urandom);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    start   = 1'b0;
    sub     = 1'b0;
    a       = '0;
    b       = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Basic add, carry-out and signed overflow
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    // Subtract with borrow and with overflow
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start held high: operands change while busy, second op accepted right after DONE
    lit_q.push_back(lit_t'{chk: 1'b1, s: 16'h3333, co: 1'b0, ovf: 1'b0});
    a     = 16'h1111;
    b     = 16'h2222;
    sub   = 1'b0;
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      a   = 16'($urandom);
      b   = 16'($urandom);
      sub = 1'($urandom);
    end
    @(negedge clk);
    lit_q.push_back(lit_t'{chk: 1'b1, s: 16'h1010, co: 1'b0, ovf: 1'b0});
    a   = 16'h0F0F;
    b   = 16'h0101;
    sub = 1'b0;
    @(negedge clk);
    a   = 16'($urandom);
    b   = 16'($urandom);
    sub = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset while idx=2; the aborted op must never report
    lit_q.push_back(lit_t'{chk: 1'b1, s: 16'h2345, co: 1'b0, ovf: 1'b0});
    a     = 16'h1234;
    b     = 16'h1111;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    run_op(16'h0100, 16'h0F00, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);

    // Random regression against the model
    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 16'h0000, 1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
